// File: rtl/exec_pkg.sv
// Shared types for the execute-issue slice: unit codes, stage-1 register and
// writeback FIFO entry layouts.
package exec_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned FUNCT_W  = 4;

    typedef enum logic [1:0] {
        UNIT_LOGIC = 2'd0,
        UNIT_ARITH = 2'd1,
        UNIT_RSVD2 = 2'd2,
        UNIT_RSVD3 = 2'd3
    } unit_e;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [XLEN_DEF-1:0] data;
        logic                err;
    } wb_entry_t;

    typedef struct packed {
        unit_e               unit;
        logic [FUNCT_W-1:0]  funct;
        logic [XLEN_DEF-1:0] op1;
        logic [XLEN_DEF-1:0] op2;
        logic [RD_W-1:0]     rd;
    } s1_t;

    function automatic logic unit_is_rsvd(input unit_e u);
        return (u == UNIT_RSVD2) || (u == UNIT_RSVD3);
    endfunction

endpackage

// File: rtl/exec_wb_fifo.sv
// Writeback FIFO: circular buffer with occupancy count, async reset and
// synchronous flush that dominates push/pop.
module exec_wb_fifo
    import exec_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  wb_entry_t                push_data_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    wb_entry_t     mem [DEPTH];
    logic          do_pop;

    assign do_pop = pop_i && (count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_i, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; an empty FIFO presents an all-zero head instead.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    assign head_o  = (count != '0) ? mem[rd_ptr] : '0;
    assign count_o = count;

endmodule

// File: rtl/exec_issue.sv
// Execute-unit issue stage: registers decoded ops toward the logical and
// arithmetic units, captures the selected result and queues it for writeback.
module exec_issue
    import exec_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  logic [1:0]      dec_unit_i,
    input  logic [3:0]      dec_funct_i,
    input  logic [XLEN-1:0] dec_op1_i,
    input  logic [XLEN-1:0] dec_op2_i,
    input  logic [4:0]      dec_rd_i,
    output logic [3:0]      funct_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic            logic_sel_o,
    output logic            arith_sel_o,
    input  logic [XLEN-1:0] logic_res_i,
    input  logic [XLEN-1:0] arith_res_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_err_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    s1_t           s1;
    logic          s1_valid;
    logic          accept;
    logic          push;
    logic          pop;
    wb_entry_t     cap;
    wb_entry_t     head;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;

    // The entry already in s1 holds a slot; a same-cycle pop is not credited.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    assign dec_ready_o = !rst_i && !flush_i && (credit_used < (CW+1)'(DEPTH));
    assign accept      = dec_valid_i && dec_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1       <= '0;
            s1_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1.unit  <= unit_e'(dec_unit_i);
                s1.funct <= dec_funct_i;
                s1.op1   <= dec_op1_i;
                s1.op2   <= dec_op2_i;
                s1.rd    <= dec_rd_i;
            end
        end
    end

    assign funct_o     = s1.funct;
    assign op1_o       = s1.op1;
    assign op2_o       = s1.op2;
    assign logic_sel_o = s1_valid && (s1.unit == UNIT_LOGIC);
    assign arith_sel_o = s1_valid && (s1.unit == UNIT_ARITH);

    always_comb begin
        cap    = '0;
        cap.rd = s1.rd;
        case (s1.unit)
            UNIT_LOGIC: cap.data = logic_res_i;
            UNIT_ARITH: cap.data = arith_res_i;
            default:    cap.err  = unit_is_rsvd(s1.unit);
        endcase
    end

    // Results for x0 are discarded unless they carry an error flag.
    assign push = s1_valid && !flush_i && ((s1.rd != '0) || cap.err);
    assign pop  = wb_valid_o && wb_ready_i;

    exec_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (cap),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign wb_valid_o = (count != '0);
    assign wb_rd_o    = head.rd;
    assign wb_data_o  = head.data;
    assign wb_err_o   = head.err;

endmodule

// File: tb/tb_exec_issue.sv
// Randomized scoreboard bench for exec_issue with directed latency, credit,
// flush and asynchronous reset scenarios.
module tb_exec_issue;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [1:0]  dec_unit_i;
    logic [3:0]  dec_funct_i;
    logic [31:0] dec_op1_i;
    logic [31:0] dec_op2_i;
    logic [4:0]  dec_rd_i;
    logic [3:0]  funct_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic        logic_sel_o;
    logic        arith_sel_o;
    logic [31:0] logic_res_i;
    logic [31:0] arith_res_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_err_o;

    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   wbv_cnt = 0;
    int   cyc = 0;
    exp_t sbq[$];
    bit   rand_done;

    exec_issue #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .dec_valid_i (dec_valid_i),
        .dec_ready_o (dec_ready_o),
        .dec_unit_i  (dec_unit_i),
        .dec_funct_i (dec_funct_i),
        .dec_op1_i   (dec_op1_i),
        .dec_op2_i   (dec_op2_i),
        .dec_rd_i    (dec_rd_i),
        .funct_o     (funct_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .logic_sel_o (logic_sel_o),
        .arith_sel_o (arith_sel_o),
        .logic_res_i (logic_res_i),
        .arith_res_i (arith_res_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .wb_err_o    (wb_err_o)
    );

    // Execution-unit stubs
    assign logic_res_i = op1_o ^ op2_o;
    assign arith_res_i = op1_o + op2_o;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    // Reference: what the register file should eventually receive for an op.
    function automatic bit model(input logic [1:0] unit, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 output exp_t e);
        e.rd   = rd;
        e.err  = (unit >= 2'd2);
        e.data = (unit == 2'd0) ? (a ^ b) : (unit == 2'd1) ? (a + b) : 32'd0;
        return (rd != 5'd0) || e.err;
    endfunction

    // Monitor: pop/compare on writeback, discard on flush/reset, record accepts.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            sbq.delete();
        end else begin
            if (wb_valid_o) wbv_cnt++;
            if (wb_valid_o && wb_ready_i) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb: got rd=%0d data=%h err=%0d, required no entry",
                             wb_rd_o, wb_data_o, wb_err_o);
                end else begin
                    e = sbq.pop_front();
                    if (wb_rd_o !== e.rd || wb_data_o !== e.data || wb_err_o !== e.err) begin
                        errors++;
                        $display("FAIL wb_entry: got rd=%0d data=%h err=%0d, required rd=%0d data=%h err=%0d",
                                 wb_rd_o, wb_data_o, wb_err_o, e.rd, e.data, e.err);
                    end
                end
            end
            if (flush_i) sbq.delete();
            if (dec_valid_i && dec_ready_o) begin
                acc_cnt++;
                if (model(dec_unit_i, dec_op1_i, dec_op2_i, dec_rd_i, e)) sbq.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Called at posedge+1; returns at accept edge+1 with dec_valid_i dropped.
    task automatic send(input logic [1:0] u, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
        bit ok;
        ok          = 1'b0;
        dec_valid_i = 1'b1;
        dec_unit_i  = u;
        dec_funct_i = f;
        dec_op1_i   = a;
        dec_op2_i   = b;
        dec_rd_i    = rd;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (dec_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        dec_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept in 200 cycles, required dec_ready_o=1");
        end
    endtask

    initial begin
        int c0, w0, a0, r;
        rst_i = 1'b1; flush_i = 1'b0; dec_valid_i = 1'b0; dec_unit_i = '0;
        dec_funct_i = '0; dec_op1_i = '0; dec_op2_i = '0; dec_rd_i = '0; wb_ready_i = 1'b1;

        #3;
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_dec_ready", 64'(dec_ready_o), 64'd0);
        chk("rst_sel", 64'({logic_sel_o, arith_sel_o}), 64'd0);
        chk("rst_operands", 64'({funct_o, op1_o}) | 64'(op2_o), 64'd0);
        chk("rst_wb_fields", 64'({wb_rd_o, wb_data_o, wb_err_o}), 64'd0);
        cyc_wait(3);
        rst_i = 1'b0;
        #1;
        chk("ready_after_rst", 64'(dec_ready_o), 64'd1);

        // Basic latency on a logical op
        send(2'd0, 4'd2, 32'hF0F0_0000, 32'h0FF0_0000, 5'd3);
        chk("lat1_logic_sel", 64'(logic_sel_o), 64'd1);
        chk("lat1_arith_sel", 64'(arith_sel_o), 64'd0);
        chk("lat1_wb_valid", 64'(wb_valid_o), 64'd0);
        cyc_wait(1);
        chk("lat2_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("lat2_wb_rd", 64'(wb_rd_o), 64'd3);
        chk("lat2_wb_data", 64'(wb_data_o), 64'hFF00_0000);
        chk("lat2_wb_err", 64'(wb_err_o), 64'd0);
        cyc_wait(3);

        // Backpressure: credit limits buffering to DEPTH entries
        wb_ready_i = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) send(2'd1, 4'd0, 32'(i), 32'd1, 5'(i + 1));
            end
            begin
                cyc_wait(20);
                chk("stall_accepts", 64'(acc_cnt - a0), 64'd4);
                chk("stall_ready", 64'(dec_ready_o), 64'd0);
                chk("stall_wb_valid", 64'(wb_valid_o), 64'd1);
                chk("stall_head_data", 64'(wb_data_o), 64'd1);
                chk("stall_head_rd", 64'(wb_rd_o), 64'd1);
                wb_ready_i = 1'b1;
            end
        join
        cyc_wait(10);
        chk("stall_drained", 64'(sbq.size()), 64'd0);

        // Sustained throughput
        c0 = cyc; w0 = wbv_cnt; a0 = acc_cnt;
        for (int i = 0; i < 20; i++)
            send(2'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, 5'($urandom_range(1, 31)));
        chk("thru_cycles", 64'(cyc - c0), 64'd20);
        chk("thru_accepts", 64'(acc_cnt - a0), 64'd20);
        cyc_wait(2);
        chk("thru_wb_cycles", 64'(wbv_cnt - w0), 64'd20);
        cyc_wait(3);

        // x0 drop and reserved-unit error
        send(2'd1, 4'd0, 32'd7, 32'd9, 5'd0);
        send(2'd3, 4'd5, 32'h1234_5678, 32'h1111_1111, 5'd5);
        chk("rd0_no_wb", 64'(wb_valid_o), 64'd0);
        cyc_wait(1);
        chk("rsvd_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("rsvd_wb_rd", 64'(wb_rd_o), 64'd5);
        chk("rsvd_wb_data", 64'(wb_data_o), 64'd0);
        chk("rsvd_wb_err", 64'(wb_err_o), 64'd1);
        cyc_wait(4);

        // Flush with three buffered entries and one op in s1
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd0, 4'd1, 32'(i * 3), 32'hA5, 5'(i + 10));
        flush_i = 1'b1;
        #1;
        chk("flush_ready_low", 64'(dec_ready_o), 64'd0);
        cyc_wait(1);
        flush_i = 1'b0;
        #1;
        chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("flush_sel", 64'({logic_sel_o, arith_sel_o}), 64'd0);
        chk("flush_ready", 64'(dec_ready_o), 64'd1);
        wb_ready_i = 1'b1;
        cyc_wait(8);
        chk("flush_no_stale", 64'(wb_valid_o), 64'd0);

        // Asynchronous reset between edges with two entries queued
        wb_ready_i = 1'b0;
        send(2'd1, 4'd0, 32'd40, 32'd2, 5'd7);
        send(2'd0, 4'd0, 32'd40, 32'd2, 5'd8);
        cyc_wait(2);
        chk("pre_rst_wb_valid", 64'(wb_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("async_rst_ready", 64'(dec_ready_o), 64'd0);
        cyc_wait(1);
        rst_i = 1'b0;
        wb_ready_i = 1'b1;
        #1;
        chk("post_rst_op1", 64'(op1_o), 64'd0);
        chk("post_rst_ready", 64'(dec_ready_o), 64'd1);
        cyc_wait(4);
        chk("post_rst_no_stale", 64'(wb_valid_o), 64'd0);

        // Randomized traffic with backpressure and occasional flushes
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 5000 && !rand_done; k++) begin
                    @(posedge clk_i);
                    #1;
                    wb_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int k = 0; k < 150; k++) begin
                    r = $urandom_range(0, 15);
                    if (r == 0) begin
                        flush_i = 1'b1;
                        cyc_wait(1);
                        flush_i = 1'b0;
                    end else if (r < 3) begin
                        cyc_wait(1);
                    end
                    send(2'($urandom_range(0, 3)), 4'($urandom), $urandom, $urandom,
                         5'($urandom_range(0, 7)));
                end
                rand_done = 1'b1;
            end
        join
        wb_ready_i = 1'b1;
        cyc_wait(20);
        chk("rand_drained", 64'(sbq.size()), 64'd0);
        chk("rand_idle_wb_valid", 64'(wb_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
